// File: rtl/ysyx_23060229_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// ysyx_23060229_mem_arbiter_pkg
// Purpose : shared encodings and defaults for the IFU/LSU memory arbiter.
//           - arbiter FSM state encoding (2-bit)
//           - requester / owner encoding (IFU=0, LSU=1), which is also the bit
//             position of that requester in the picker's one-hot grant
//           - default watchdog limit and counter width
// Ports   : none (package)
// -----------------------------------------------------------------------------
package ysyx_23060229_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_IFU = 1'b0,
        OWNER_LSU = 1'b1
    } owner_e;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 32'd255;
    localparam int unsigned DEFAULT_CNT_W          = 32'd16;

endpackage : ysyx_23060229_mem_arbiter_pkg

// File: rtl/ysyx_23060229_mem_arbiter_pick.sv
// -----------------------------------------------------------------------------
// ysyx_23060229_arb_pick
// Purpose : combinational two-way picker between IFU and LSU requests.
//           Returns a one-hot grant indexed by owner encoding
//           (bit 0 = IFU, bit 1 = LSU), or 0 when nobody requests.
// Config  : YSYX_23060229_ARB_RR_EN
//           defined   -> round-robin: on a tie the requester that was NOT
//                        served last wins (last_owner_i selects)
//           undefined -> fixed priority, LSU beats IFU; no last_owner_i port
// Ports   : ifu_valid_i   IFU request valid
//           lsu_valid_i   LSU request valid
//           last_owner_i  owner of the previous grant (round-robin build only)
//           grant_o[1:0]  one-hot grant
// -----------------------------------------------------------------------------
module ysyx_23060229_arb_pick
    import ysyx_23060229_mem_arbiter_pkg::*;
(
    input  logic       ifu_valid_i,
    input  logic       lsu_valid_i,
`ifdef YSYX_23060229_ARB_RR_EN
    input  logic       last_owner_i,
`endif
    output logic [1:0] grant_o
);

    // Winner selection; only a simultaneous request needs the tie-break.
    always_comb begin
        grant_o = 2'b00;
        if (ifu_valid_i && lsu_valid_i) begin
`ifdef YSYX_23060229_ARB_RR_EN
            if (last_owner_i == OWNER_IFU) begin
                grant_o = 2'b10;
            end else begin
                grant_o = 2'b01;
            end
`else
            grant_o = 2'b10;
`endif
        end else if (lsu_valid_i) begin
            grant_o = 2'b10;
        end else if (ifu_valid_i) begin
            grant_o = 2'b01;
        end else begin
            grant_o = 2'b00;
        end
    end

endmodule : ysyx_23060229_arb_pick

// File: rtl/ysyx_23060229_mem_arbiter.sv
// -----------------------------------------------------------------------------
// ysyx_23060229_mem_arbiter
// Purpose : shares the single memory port between instruction fetch (IFU,
//           read-only) and load/store (LSU). One transaction outstanding at a
//           time: IDLE grants, REQ presents the latched request to memory,
//           WAIT forwards the response to the owner. A watchdog turns a hung
//           access into a one-cycle error response.
// Config  : YSYX_23060229_ARB_RR_EN -- round-robin tie-break with a last_owner
//           register; undefined gives fixed LSU-over-IFU priority.
// Params  : TIMEOUT_CYCLES  cycles from grant to forced error (1..65535)
//           CNT_W           watchdog counter width
// Ports   : clk, rst                      clock, synchronous active-high reset
//           ifu_req_* / ifu_addr_i        fetch request channel
//           ifu_resp_* / ifu_rdata_o      fetch response (no back-pressure)
//           lsu_req_* / lsu_addr_i,
//           lsu_wen_i, lsu_wdata_i,
//           lsu_wmask_i                   load/store request channel
//           lsu_resp_* / lsu_rdata_o      load/store response (no back-pressure)
//           mem_req_* / mem_addr_o,
//           mem_wen_o, mem_wdata_o,
//           mem_wmask_o                   latched request toward memory
//           mem_resp_valid_i, mem_rdata_i memory response
// -----------------------------------------------------------------------------
module ysyx_23060229_mem_arbiter
    import ysyx_23060229_mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ifu_req_valid_i,
    output logic        ifu_req_ready_o,
    input  logic [31:0] ifu_addr_i,
    output logic        ifu_resp_valid_o,
    output logic [31:0] ifu_rdata_o,
    output logic        ifu_resp_err_o,

    input  logic        lsu_req_valid_i,
    output logic        lsu_req_ready_o,
    input  logic [31:0] lsu_addr_i,
    input  logic        lsu_wen_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [7:0]  lsu_wmask_i,
    output logic        lsu_resp_valid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_resp_err_o,

    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_wen_o,
    output logic [31:0] mem_wdata_o,
    output logic [7:0]  mem_wmask_o,
    input  logic        mem_resp_valid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [31:0]       addr_q,  addr_d;
    logic              wen_q,   wen_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [7:0]        wmask_q, wmask_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
`ifdef YSYX_23060229_ARB_RR_EN
    owner_e            last_owner_q, last_owner_d;
`endif

    logic [1:0]        grant_s;
    logic              idle_s;
    logic              busy_s;
    logic              ifu_ready_s;
    logic              lsu_ready_s;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic              real_resp_s;
    logic              timeout_s;
    logic              resp_s;

    ysyx_23060229_arb_pick u_pick (
        .ifu_valid_i  (ifu_req_valid_i),
        .lsu_valid_i  (lsu_req_valid_i),
`ifdef YSYX_23060229_ARB_RR_EN
        .last_owner_i (last_owner_q),
`endif
        .grant_o      (grant_s)
    );

    // A cycle with rst high is already an abort: no grant and no response.
    assign idle_s      = (state_q == ARB_IDLE) && !rst;
    assign busy_s      = (state_q == ARB_REQ) || (state_q == ARB_WAIT);
    assign ifu_ready_s = idle_s && grant_s[0];
    assign lsu_ready_s = idle_s && grant_s[1];

    // The compare uses the incremented count so the error lands exactly
    // TIMEOUT_CYCLES cycles after the grant (count is 0 in the first REQ cycle).
    assign cnt_inc_s   = cnt_q + CNT_W'(1);
    assign real_resp_s = (state_q == ARB_WAIT) && mem_resp_valid_i && !rst;
    // A real response in the same cycle beats the watchdog.
    assign timeout_s   = busy_s && (cnt_inc_s >= TIMEOUT_C) && !real_resp_s && !rst;
    assign resp_s      = real_resp_s || timeout_s;

    assign ifu_req_ready_o  = ifu_ready_s;
    assign lsu_req_ready_o  = lsu_ready_s;

    assign ifu_resp_valid_o = resp_s && (owner_q == OWNER_IFU);
    assign ifu_resp_err_o   = timeout_s && (owner_q == OWNER_IFU);
    assign ifu_rdata_o      = (real_resp_s && (owner_q == OWNER_IFU)) ? mem_rdata_i : 32'h0;

    assign lsu_resp_valid_o = resp_s && (owner_q == OWNER_LSU);
    assign lsu_resp_err_o   = timeout_s && (owner_q == OWNER_LSU);
    assign lsu_rdata_o      = (real_resp_s && (owner_q == OWNER_LSU)) ? mem_rdata_i : 32'h0;

    // The request drops in the cycle the watchdog fires so memory never
    // accepts an access that has already been answered with an error.
    assign mem_req_valid_o  = (state_q == ARB_REQ) && !timeout_s && !rst;
    assign mem_addr_o       = addr_q;
    assign mem_wen_o        = wen_q;
    assign mem_wdata_o      = wdata_q;
    assign mem_wmask_o      = wmask_q;

    // Next-state logic: grant/latch in IDLE, watchdog counting while busy.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        cnt_d   = cnt_q;
`ifdef YSYX_23060229_ARB_RR_EN
        last_owner_d = last_owner_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (lsu_ready_s) begin
                    owner_d = OWNER_LSU;
                    addr_d  = lsu_addr_i;
                    wen_d   = lsu_wen_i;
                    wdata_d = lsu_wdata_i;
                    wmask_d = lsu_wmask_i;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ARB_REQ;
`ifdef YSYX_23060229_ARB_RR_EN
                    last_owner_d = OWNER_LSU;
`endif
                end else if (ifu_ready_s) begin
                    // Fetches never write: side-band fields are forced to zero.
                    owner_d = OWNER_IFU;
                    addr_d  = ifu_addr_i;
                    wen_d   = 1'b0;
                    wdata_d = 32'h0;
                    wmask_d = 8'h00;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ARB_REQ;
`ifdef YSYX_23060229_ARB_RR_EN
                    last_owner_d = OWNER_IFU;
`endif
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_REQ: begin
                cnt_d = (cnt_q >= TIMEOUT_C) ? TIMEOUT_C : cnt_inc_s;
                if (timeout_s) begin
                    state_d = ARB_IDLE;
                end else if (mem_req_ready_i) begin
                    state_d = ARB_WAIT;
                end else begin
                    state_d = ARB_REQ;
                end
            end
            ARB_WAIT: begin
                cnt_d = (cnt_q >= TIMEOUT_C) ? TIMEOUT_C : cnt_inc_s;
                if (resp_s) begin
                    state_d = ARB_IDLE;
                end else begin
                    state_d = ARB_WAIT;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State, owner, latched request and watchdog registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= OWNER_IFU;
            addr_q  <= 32'h0;
            wen_q   <= 1'b0;
            wdata_q <= 32'h0;
            wmask_q <= 8'h00;
            cnt_q   <= {CNT_W{1'b0}};
`ifdef YSYX_23060229_ARB_RR_EN
            last_owner_q <= OWNER_IFU;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            cnt_q   <= cnt_d;
`ifdef YSYX_23060229_ARB_RR_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

endmodule : ysyx_23060229_mem_arbiter

// File: tb/tb_ysyx_23060229_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ysyx_23060229_mem_arbiter
// Directed bench for the IFU/LSU memory arbiter. Instance dut uses the default
// watchdog limit; instance dut_t shares the same inputs with TIMEOUT_CYCLES=8
// and is only examined in the watchdog sequence (after a fresh reset).
// Expectations for the tie sequence follow YSYX_23060229_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_ysyx_23060229_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid;
    logic [31:0] ifu_addr;
    logic        lsu_req_valid;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    logic        ifu_req_ready, ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_rdata;
    logic        lsu_req_ready, lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;

    logic        t_ifu_req_ready, t_ifu_resp_valid, t_ifu_resp_err;
    logic [31:0] t_ifu_rdata;
    logic        t_lsu_req_ready, t_lsu_resp_valid, t_lsu_resp_err;
    logic [31:0] t_lsu_rdata;
    logic        t_mem_req_valid, t_mem_wen;
    logic [31:0] t_mem_addr, t_mem_wdata;
    logic [7:0]  t_mem_wmask;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    ysyx_23060229_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid_i(ifu_req_valid), .ifu_req_ready_o(ifu_req_ready),
        .ifu_addr_i(ifu_addr), .ifu_resp_valid_o(ifu_resp_valid),
        .ifu_rdata_o(ifu_rdata), .ifu_resp_err_o(ifu_resp_err),
        .lsu_req_valid_i(lsu_req_valid), .lsu_req_ready_o(lsu_req_ready),
        .lsu_addr_i(lsu_addr), .lsu_wen_i(lsu_wen), .lsu_wdata_i(lsu_wdata),
        .lsu_wmask_i(lsu_wmask), .lsu_resp_valid_o(lsu_resp_valid),
        .lsu_rdata_o(lsu_rdata), .lsu_resp_err_o(lsu_resp_err),
        .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
        .mem_addr_o(mem_addr), .mem_wen_o(mem_wen), .mem_wdata_o(mem_wdata),
        .mem_wmask_o(mem_wmask), .mem_resp_valid_i(mem_resp_valid),
        .mem_rdata_i(mem_rdata)
    );

    ysyx_23060229_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut_t (
        .clk(clk), .rst(rst),
        .ifu_req_valid_i(ifu_req_valid), .ifu_req_ready_o(t_ifu_req_ready),
        .ifu_addr_i(ifu_addr), .ifu_resp_valid_o(t_ifu_resp_valid),
        .ifu_rdata_o(t_ifu_rdata), .ifu_resp_err_o(t_ifu_resp_err),
        .lsu_req_valid_i(lsu_req_valid), .lsu_req_ready_o(t_lsu_req_ready),
        .lsu_addr_i(lsu_addr), .lsu_wen_i(lsu_wen), .lsu_wdata_i(lsu_wdata),
        .lsu_wmask_i(lsu_wmask), .lsu_resp_valid_o(t_lsu_resp_valid),
        .lsu_rdata_o(t_lsu_rdata), .lsu_resp_err_o(t_lsu_resp_err),
        .mem_req_valid_o(t_mem_req_valid), .mem_req_ready_i(mem_req_ready),
        .mem_addr_o(t_mem_addr), .mem_wen_o(t_mem_wen), .mem_wdata_o(t_mem_wdata),
        .mem_wmask_o(t_mem_wmask), .mem_resp_valid_i(mem_resp_valid),
        .mem_rdata_i(mem_rdata)
    );

    typedef struct {
        logic ifu_v;
        logic lsu_v;
        logic mresp;
        logic e_ifu_rdy;
        logic e_lsu_rdy;
        logic e_ifu_resp;
        logic e_lsu_resp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        vecs [5];
        logic [1:0]  tie_exp [3];
        logic [31:0] saved_ifu_addr;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        // {ifu_ready, lsu_ready} per back-to-back tie
`ifdef YSYX_23060229_ARB_RR_EN
        tie_exp[0] = 2'b01; tie_exp[1] = 2'b10; tie_exp[2] = 2'b01;
`else
        tie_exp[0] = 2'b01; tie_exp[1] = 2'b01; tie_exp[2] = 2'b01;
`endif

        rst = 1'b1;
        ifu_req_valid = 1'b0; ifu_addr = 32'h0;
        lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0;
        lsu_wdata = 32'h0; lsu_wmask = 8'h00;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'hA5A5A5A5;
        tick(); tick();
        rst = 1'b0;
        #1;

        // ---------------- reset state ----------------
        chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'h0);
        chk("rst_mem_addr",  mem_addr, 32'h0);
        chk("rst_mem_wen",   {31'b0, mem_wen}, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_wmask", {24'b0, mem_wmask}, 32'h0);
        chk("rst_readies",   {30'b0, ifu_req_ready, lsu_req_ready}, 32'h0);
        chk("rst_resp",      {28'b0, ifu_resp_valid, lsu_resp_valid, ifu_resp_err, lsu_resp_err}, 32'h0);
        chk("rst_ifu_rdata", ifu_rdata, 32'h0);
        chk("rst_lsu_rdata", lsu_rdata, 32'h0);

        // ---------------- IDLE arbitration table ----------------
        tick();
        for (int i = 0; i < 5; i++) begin
            ifu_req_valid  = vecs[i].ifu_v;
            lsu_req_valid  = vecs[i].lsu_v;
            mem_resp_valid = vecs[i].mresp;
            #1;
            chk($sformatf("vec%0d_ready", i), {30'b0, ifu_req_ready, lsu_req_ready},
                {30'b0, vecs[i].e_ifu_rdy, vecs[i].e_lsu_rdy});
            chk($sformatf("vec%0d_resp", i), {30'b0, ifu_resp_valid, lsu_resp_valid},
                {30'b0, vecs[i].e_ifu_resp, vecs[i].e_lsu_resp});
            ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_resp_valid = 1'b0;
            tick();
        end
        chk("vec_no_grant_leak", {31'b0, mem_req_valid}, 32'h0);

        // ---------------- IFU-only fetch ----------------
        ifu_req_valid = 1'b1; ifu_addr = 32'h80000000;
        #1;
        chk("f1_ifu_ready", {31'b0, ifu_req_ready}, 32'h1);
        tick();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        #1;
        chk("f1_mem_req_valid", {31'b0, mem_req_valid}, 32'h1);
        chk("f1_mem_addr", mem_addr, 32'h80000000);
        chk("f1_mem_wen",  {31'b0, mem_wen}, 32'h0);
        chk("f1_no_ready", {30'b0, ifu_req_ready, lsu_req_ready}, 32'h0);
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h00000413;
        #1;
        chk("f1_ifu_resp",  {31'b0, ifu_resp_valid}, 32'h1);
        chk("f1_ifu_rdata", ifu_rdata, 32'h00000413);
        chk("f1_ifu_err",   {31'b0, ifu_resp_err}, 32'h0);
        chk("f1_lsu_quiet", {31'b0, lsu_resp_valid}, 32'h0);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("f1_resp_one_cycle", {31'b0, ifu_resp_valid}, 32'h0);

        // ---------------- simultaneous IFU + LSU store ----------------
        ifu_req_valid = 1'b1; ifu_addr = 32'h80000004;
        lsu_req_valid = 1'b1; lsu_addr = 32'h80001000; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEADBEEF; lsu_wmask = 8'h0F;
        #1;
        chk("t2_grant", {30'b0, ifu_req_ready, lsu_req_ready}, 32'h1);
        tick();
        lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
        #1;
        chk("t2_mem_addr",  mem_addr, 32'h80001000);
        chk("t2_mem_wen",   {31'b0, mem_wen}, 32'h1);
        chk("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("t2_mem_wmask", {24'b0, mem_wmask}, 32'h0F);
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
        #1;
        chk("t2_lsu_resp", {30'b0, ifu_resp_valid, lsu_resp_valid}, 32'h1);
        chk("t2_ifu_wait", {31'b0, ifu_req_ready}, 32'h0);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("t2_ifu_grant_next", {30'b0, ifu_req_ready, lsu_req_ready}, 32'h2);
        tick();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        #1;
        chk("t2_ifu_fields", {mem_addr[31:9], mem_wen, mem_wmask},
            {23'h400000, 1'b0, 8'h00});
        chk("t2_ifu_addr",  mem_addr, 32'h80000004);
        chk("t2_ifu_wdata", mem_wdata, 32'h0);
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h00100093;
        #1;
        chk("t2_ifu_rdata", ifu_rdata, 32'h00100093);
        tick();
        mem_resp_valid = 1'b0;

        // ---------------- three back-to-back ties ----------------
        for (int k = 0; k < 3; k++) begin
            ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
            #1;
            chk($sformatf("tie%0d_grant", k), {30'b0, ifu_req_ready, lsu_req_ready},
                {30'b0, tie_exp[k]});
            tick();
            if (tie_exp[k][0]) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
            mem_req_ready = 1'b1;
            #1;
            chk($sformatf("tie%0d_wen", k), {31'b0, mem_wen}, {31'b0, tie_exp[k][0]});
            tick();
            mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
            #1;
            chk($sformatf("tie%0d_resp", k), {30'b0, ifu_resp_valid, lsu_resp_valid},
                {30'b0, tie_exp[k]});
            tick();
            mem_resp_valid = 1'b0;
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        tick();

        // ---------------- mem_req_ready stalled 10 cycles ----------------
        lsu_req_valid = 1'b1; lsu_addr = 32'h12345670; lsu_wen = 1'b0;
        lsu_wdata = 32'h0; lsu_wmask = 8'hFF;
        #1;
        chk("s_grant", {31'b0, lsu_req_ready}, 32'h1);
        tick();
        lsu_req_valid = 1'b0; ifu_req_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            mem_req_ready = 1'b0;
            lsu_addr  = $urandom; lsu_wdata = $urandom; lsu_wmask = 8'(c);
            ifu_addr  = $urandom; lsu_wen = ~lsu_wen;
            #1;
            chk($sformatf("s%0d_valid", c), {30'b0, mem_req_valid, ifu_req_ready}, 32'h2);
            chk($sformatf("s%0d_addr", c), mem_addr, 32'h12345670);
            chk($sformatf("s%0d_side", c), {mem_wdata[30:0], mem_wen}, {31'h0, 1'b0});
            chk($sformatf("s%0d_wmask", c), {24'b0, mem_wmask}, 32'hFF);
            tick();
        end
        mem_req_ready = 1'b1;
        saved_ifu_addr = ifu_addr;
        #1;
        chk("s_final_addr", mem_addr, 32'h12345670);
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hCAFEF00D;
        #1;
        chk("s_lsu_resp",  {31'b0, lsu_resp_valid}, 32'h1);
        chk("s_lsu_rdata", lsu_rdata, 32'hCAFEF00D);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("s_ifu_grant", {31'b0, ifu_req_ready}, 32'h1);
        tick();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        #1;
        chk("s_ifu_addr", mem_addr, saved_ifu_addr);
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;

        // ---------------- reset while in WAIT ----------------
        ifu_req_valid = 1'b1; ifu_addr = 32'h80000100;
        tick();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; rst = 1'b1; mem_resp_valid = 1'b1;
        #1;
        chk("r_no_resp", {30'b0, ifu_resp_valid, lsu_resp_valid}, 32'h0);
        tick();
        rst = 1'b0; mem_resp_valid = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h80000200;
        #1;
        chk("r_outputs_zero", {mem_addr[29:0], mem_req_valid, mem_wen}, 32'h0);
        chk("r_resp_zero", {28'b0, ifu_resp_valid, lsu_resp_valid, ifu_resp_err, lsu_resp_err}, 32'h0);
        chk("r_new_grant", {30'b0, ifu_req_ready, lsu_req_ready}, 32'h2);
        tick();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        #1;
        chk("r_new_req", {31'b0, mem_req_valid}, 32'h1);
        chk("r_new_addr", mem_addr, 32'h80000200);
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;

        // ---------------- watchdog (dut_t, TIMEOUT_CYCLES=8) ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0; mem_rdata = 32'hFFFFFFFF;
        #1;
        chk("w_reset_zero", {31'b0, |{t_ifu_req_ready, t_ifu_rdata, t_ifu_resp_err,
            t_lsu_req_ready, t_lsu_rdata, t_lsu_resp_err, t_ifu_resp_valid,
            t_lsu_resp_valid, t_mem_req_valid, t_mem_addr, t_mem_wen,
            t_mem_wdata, t_mem_wmask}}, 32'h0);
        lsu_req_valid = 1'b1; lsu_addr = 32'h80002000; lsu_wen = 1'b0;
        #1;
        chk("w_grant", {31'b0, t_lsu_req_ready}, 32'h1);
        tick();
        lsu_req_valid = 1'b0;
        for (int c = 1; c < 8; c++) begin
            mem_req_ready = (c == 1);
            #1;
            chk($sformatf("w_quiet_%0d", c), {30'b0, t_lsu_resp_valid, t_lsu_resp_err}, 32'h0);
            tick();
        end
        mem_req_ready = 1'b0;
        #1;
        chk("w_err_resp", {29'b0, t_ifu_resp_valid, t_lsu_resp_valid, t_lsu_resp_err}, 32'h3);
        chk("w_err_rdata", t_lsu_rdata, 32'h0);
        chk("w_req_dropped", {31'b0, t_mem_req_valid}, 32'h0);
        tick();
        mem_resp_valid = 1'b1;
        #1;
        chk("w_late_ignored", {30'b0, t_ifu_resp_valid, t_lsu_resp_valid}, 32'h0);
        tick();
        mem_resp_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_ysyx_23060229_mem_arbiter
